// File: rtl/nand_pkg.sv
// Shared NAND PHY constants: read FSM encodings and strobe timing.
// Used by the read capture block and the write-strobe toggler.
package nand_pkg;

  localparam logic [2:0] RD_IDLE  = 3'd0;
  localparam logic [2:0] RD_LOW   = 3'd1;
  localparam logic [2:0] RD_HIGH  = 3'd2;
  localparam logic [2:0] RD_STALL = 3'd3;
  localparam logic [2:0] RD_DRAIN = 3'd4;
  localparam logic [2:0] RD_DONE  = 3'd5;

  localparam int SETUP_CYC_DEF = 3;
  localparam int HOLD_CYC_DEF  = 2;

endpackage

// File: rtl/nand_rd_fifo.sv
// First-word fall-through capture FIFO for NAND read data.
// Head byte is visible on dout while not empty; dout reads 0 when empty.
module nand_rd_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap since depth is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nand_read_capture.sv
// NAND data-out burst engine: drives RE# and captures DQ per byte.
// Captured bytes are queued in a small FWFT FIFO for the controller.
module nand_read_capture
  import nand_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int CNT_W      = 12,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic [DATA_W-1:0] dq_in,
  output logic              re_n,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bytes_rcvd
);

  localparam int DLY_W = 8;
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  logic [2:0]       state;
  logic [2:0]       state_nx;
  logic [DLY_W-1:0] dly;
  logic [DLY_W-1:0] dly_nx;
  logic [CNT_W-1:0] cnt_lat;
  logic             start;
  logic             push;
  logic             low_last;
  logic             high_last;
  logic             fifo_empty;
  logic             fifo_full;
  logic [FCW-1:0]   fifo_count;

  assign low_last   = (dly == DLY_W'(SETUP_CYC - 1));
  assign high_last  = (dly == DLY_W'(HOLD_CYC - 1));
  assign re_n       = (state != RD_LOW);
  assign busy       = (state != RD_IDLE);
  assign done       = (state == RD_DONE);
  assign dout_valid = ~fifo_empty;

  // Next-state, delay counter and push decode.
  always_comb begin
    state_nx = state;
    dly_nx   = '0;
    push     = 1'b0;
    start    = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (enable) begin
          start    = 1'b1;
          state_nx = (byte_count != '0) ? RD_LOW : RD_DONE;
        end
      end
      RD_LOW: begin
        if (low_last) begin
          push     = 1'b1;
          state_nx = RD_HIGH;
        end else begin
          dly_nx = dly + 1'b1;
        end
      end
      RD_HIGH: begin
        if (high_last) begin
          if (bytes_rcvd == cnt_lat) state_nx = RD_DRAIN;
          else if (fifo_full)        state_nx = RD_STALL;
          else                       state_nx = RD_LOW;
        end else begin
          dly_nx = dly + 1'b1;
        end
      end
      RD_STALL: begin
        if (fifo_count < FCW'(FIFO_DEPTH)) state_nx = RD_LOW;
      end
      RD_DRAIN: begin
        if (fifo_empty) state_nx = RD_DONE;
      end
      RD_DONE: begin
        if (!enable) state_nx = RD_IDLE;
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  // State, delay, latched length and received-byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RD_IDLE;
      dly        <= '0;
      cnt_lat    <= '0;
      bytes_rcvd <= '0;
    end else begin
      state <= state_nx;
      dly   <= dly_nx;
      if (start) begin
        cnt_lat    <= byte_count;
        bytes_rcvd <= '0;
      end else if (push) begin
        bytes_rcvd <= bytes_rcvd + 1'b1;
      end
    end
  end

  nand_rd_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (dq_in),
    .pop   (dout_ready),
    .dout  (dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_nand_read_capture.sv
// Directed bench for nand_read_capture: burst table plus corner sequences.
// DQ returns 8'hA0 + byte index while RE# is low.
module tb_nand_read_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [11:0] byte_count;
  logic [7:0]  dq_in;
  logic        re_n;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
  logic        done;
  logic [11:0] bytes_rcvd;

  always #5 clk = ~clk;

  nand_read_capture dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .byte_count (byte_count),
    .dq_in      (dq_in),
    .re_n       (re_n),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done),
    .bytes_rcvd (bytes_rcvd)
  );

  typedef struct {
    int cnt;
    bit tog;
    int hold;
    int exp_hp;
    int exp_rcvd;
  } vec_t;

  vec_t       vecs [5];
  int         n_cmp = 0;
  int         n_err = 0;
  int         falls;
  int         rises;
  int         pops;
  int         max_occ;
  logic       prev_re;
  logic [7:0] rx_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic clr();
    falls   = 0;
    rises   = 0;
    pops    = 0;
    max_occ = 0;
    prev_re = 1'b1;
    rx_q.delete();
  endtask

  // One cycle: sample at negedge, set ready, log pops and RE# edges.
  task automatic step(input logic rdy);
    @(negedge clk);
    dout_ready = rdy;
    if (prev_re && !re_n) falls++;
    if (!prev_re && re_n) rises++;
    prev_re = re_n;
    if (!re_n) dq_in = 8'hA0 + 8'(falls - 1);
    if (rises - pops > max_occ) max_occ = rises - pops;
    if (dout_valid && rdy) begin
      rx_q.push_back(dout);
      pops++;
    end
  endtask

  task automatic chk_rx(input int n);
    chk("rx_len", rx_q.size(), n);
    for (int k = 0; k < rx_q.size() && k < n; k++)
      chk("rx_byte", int'(rx_q[k]), 'hA0 + k);
  endtask

  task automatic run_burst(input vec_t v);
    bit   ok;
    logic rdy;
    clr();
    ok         = 1'b0;
    byte_count = 12'(v.cnt);
    enable     = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i < v.hold) rdy = 1'b0;
      else if (v.tog) rdy = i[0];
      else rdy = 1'b1;
      step(rdy);
      if (v.hold != 0 && i == v.hold - 1) begin
        chk("stall_pulses", falls, v.exp_hp);
        chk("stall_re_n", int'(re_n), 1);
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("burst_done", int'(ok), 1);
    chk("pulses", falls, v.exp_rcvd);
    chk("bytes_rcvd", int'(bytes_rcvd), v.exp_rcvd);
    chk("occ_le_4", int'(max_occ <= 4), 1);
    chk_rx(v.exp_rcvd);
    enable = 1'b0;
    step(1'b1);
    chk("done_clear", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    logic [14:0] pat;
    vec_t        v;
    bit          seen;

    vecs[0] = '{cnt: 3, tog: 1'b0, hold: 0,  exp_hp: 0, exp_rcvd: 3};
    vecs[1] = '{cnt: 8, tog: 1'b0, hold: 40, exp_hp: 4, exp_rcvd: 8};
    vecs[2] = '{cnt: 6, tog: 1'b1, hold: 0,  exp_hp: 0, exp_rcvd: 6};
    vecs[3] = '{cnt: 1, tog: 1'b0, hold: 0,  exp_hp: 0, exp_rcvd: 1};
    vecs[4] = '{cnt: 4, tog: 1'b0, hold: 40, exp_hp: 4, exp_rcvd: 4};

    reset      = 1'b1;
    enable     = 1'b0;
    byte_count = '0;
    dq_in      = '0;
    dout_ready = 1'b0;
    clr();
    step(1'b0);
    step(1'b0);
    chk("rst_re_n", int'(re_n), 1);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rcvd", int'(bytes_rcvd), 0);
    chk("rst_dout", int'(dout), 0);
    reset = 1'b0;
    step(1'b0);

    // Exact RE# waveform and done timing for a 3-byte burst.
    clr();
    pat        = 15'b000110001100011;
    byte_count = 12'd3;
    enable     = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(1'b1);
      chk("re_n_pat", int'(re_n), int'(pat[14-i]));
    end
    step(1'b1);
    chk("drain_done", int'(done), 0);
    step(1'b1);
    chk("done_rise", int'(done), 1);
    step(1'b1);
    step(1'b1);
    chk("done_hold", int'(done), 1);
    chk("basic_rcvd", int'(bytes_rcvd), 3);
    chk_rx(3);
    enable = 1'b0;
    step(1'b1);
    chk("basic_done_clr", int'(done), 0);

    foreach (vecs[j]) run_burst(vecs[j]);

    // Zero-length request goes straight to done, no strobe.
    clr();
    byte_count = 12'd0;
    enable     = 1'b1;
    step(1'b1);
    chk("zero_done", int'(done), 1);
    step(1'b1);
    chk("zero_re_n", int'(re_n), 1);
    chk("zero_falls", falls, 0);
    enable = 1'b0;
    step(1'b1);
    chk("zero_done_clr", int'(done), 0);

    // Reset during the second RE# low phase.
    clr();
    byte_count = 12'd5;
    enable     = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0);
      if (falls == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_reach", int'(seen), 1);
    chk("mid_valid_pre", int'(dout_valid), 1);
    reset  = 1'b1;
    enable = 1'b0;
    step(1'b0);
    chk("mid_re_n", int'(re_n), 1);
    chk("mid_valid", int'(dout_valid), 0);
    chk("mid_rcvd", int'(bytes_rcvd), 0);
    chk("mid_busy", int'(busy), 0);
    reset = 1'b0;
    step(1'b0);
    v = '{cnt: 2, tog: 1'b0, hold: 0, exp_hp: 0, exp_rcvd: 2};
    run_burst(v);

    // Enable dropped during byte 2: burst still completes.
    clr();
    byte_count = 12'd4;
    enable     = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1'b1);
      if (falls == 2) enable = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("glitch_done", int'(seen), 1);
    chk("glitch_rcvd", int'(bytes_rcvd), 4);
    chk_rx(4);
    step(1'b1);
    chk("glitch_done_clr", int'(done), 0);
    chk("glitch_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
